// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use and HI/LO stalls,
// exception/ERET redirection with a one-cycle recovery window that drops wrong-path requests.
module pipe_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_rs_use,
    input  logic       id_rt_use,
    input  logic       id_md_use,
    input  logic       ex_load,
    input  logic [4:0] ex_dst,
    input  logic       ex_md_start,
    input  logic       ex_md_div,
    input  logic       exc_req,
    input  logic       eret_req,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       if_id_we,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       md_busy
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] md_cnt_r;
    logic             load_use_s;
    logic             md_stall_s;
    logic             stall_s;

    assign md_busy    = (md_cnt_r != CNT_ZERO);
    assign load_use_s = id_valid & ex_load & (ex_dst != 5'd0) &
                        ((id_rs_use & (id_rs == ex_dst)) | (id_rt_use & (id_rt == ex_dst)));
    assign md_stall_s = id_valid & id_md_use & md_busy;
    assign stall_s    = load_use_s | md_stall_s;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // mult/div latency counter; a new issue reloads even mid-count, exceptions leave it running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_r <= CNT_ZERO;
        end else if (ex_md_start) begin
            md_cnt_r <= ex_md_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_cnt_r != CNT_ZERO) begin
            md_cnt_r <= md_cnt_r - CNT_ONE;
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // Next-state and pipeline control outputs; redirects override any stall
    always_comb begin
        state_nxt_s  = state_r;
        pc_we        = 1'b1;
        pc_src       = 2'b00;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!reset) begin
            state_nxt_s  = ST_RUN;
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (exc_req || eret_req) begin
                        state_nxt_s  = ST_RECOVER;
                        pc_src       = exc_req ? 2'b01 : 2'b10;
                        if_id_we     = 1'b0;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (stall_s) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_RECOVER: begin
                    // requests seen here come from the squashed wrong path
                    state_nxt_s = ST_RUN;
                    if (stall_s) begin
                        pc_we       = 1'b0;
                        if_id_we    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_we = 1'b1;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a reference model pushes expected outputs to a
// scoreboard queue as stimulus is applied; the queue is popped and compared mid-cycle.
module tb_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_use;
    logic       id_rt_use;
    logic       id_md_use;
    logic       ex_load;
    logic [4:0] ex_dst;
    logic       ex_md_start;
    logic       ex_md_div;
    logic       exc_req;
    logic       eret_req;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       if_id_we;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       ex_mem_flush;
    logic       md_busy;

    int         err_cnt;
    int         chk_cnt;
    int         m_cnt;
    bit         m_rec;
    logic [7:0] exp_q[$];
    logic [7:0] last_got;

    pipe_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_use(id_rs_use), .id_rt_use(id_rt_use), .id_md_use(id_md_use),
        .ex_load(ex_load), .ex_dst(ex_dst), .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
        .exc_req(exc_req), .eret_req(eret_req), .pc_we(pc_we), .pc_src(pc_src),
        .if_id_we(if_id_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .md_busy(md_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {pc_we, pc_src, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush, md_busy}
    function automatic logic [7:0] model_out();
        bit busy;
        bit stall;
        busy  = (m_cnt != 0);
        stall = (id_valid && ex_load && ex_dst != 5'd0 &&
                 ((id_rs_use && id_rs == ex_dst) || (id_rt_use && id_rt == ex_dst))) ||
                (id_valid && id_md_use && busy);
        if (!reset)                           return 8'b0_00_0_1_1_1_0;
        if (!m_rec && (exc_req || eret_req))  return {1'b1, (exc_req ? 2'b01 : 2'b10), 4'b0111, busy};
        if (stall)                            return {1'b0, 2'b00, 4'b0010, busy};
        return {1'b1, 2'b00, 4'b1000, busy};
    endfunction

    task automatic step();
        logic [7:0] e;
        if (!reset) begin
            m_cnt = 0;
            m_rec = 1'b0;
        end
        exp_q.push_back(model_out());
        @(negedge clk);
        last_got = {pc_we, pc_src, if_id_we, if_id_flush, id_ex_flush, ex_mem_flush, md_busy};
        e = exp_q.pop_front();
        check("cycle", {24'd0, last_got}, {24'd0, e});
        @(posedge clk);
        if (!reset) begin
            m_cnt = 0;
            m_rec = 1'b0;
        end else begin
            if (ex_md_start)     m_cnt = ex_md_div ? 10 : 5;
            else if (m_cnt > 0)  m_cnt = m_cnt - 1;
            m_rec = !m_rec && (exc_req || eret_req);
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_rs = 5'd0; id_rt = 5'd0; id_rs_use = 1'b0; id_rt_use = 1'b0;
        id_md_use = 1'b0; ex_load = 1'b0; ex_dst = 5'd0; ex_md_start = 1'b0; ex_md_div = 1'b0;
        exc_req = 1'b0; eret_req = 1'b0;
    endtask

    initial begin
        int n;
        err_cnt = 0;
        chk_cnt = 0;
        m_cnt   = 0;
        m_rec   = 1'b0;
        idle_inputs();
        reset = 1'b0;
        #1;
        step();
        check("rst_hold", {24'd0, last_got}, {24'd0, 8'b0_00_0_1_1_1_0});
        reset = 1'b1;
        step();
        check("run_idle", {24'd0, last_got}, {24'd0, 8'b1_00_1_0_0_0_0});

        // reset asserted mid-mult
        ex_md_start = 1'b1;
        step();
        ex_md_start = 1'b0;
        step();
        step();
        check("mult_cnt3_busy", {31'd0, last_got[0]}, 32'd1);
        reset = 1'b0;
        step();
        check("rst_mid_mult", {24'd0, last_got}, {24'd0, 8'b0_00_0_1_1_1_0});
        reset = 1'b1;
        step();
        check("rst_release", {24'd0, last_got}, {24'd0, 8'b1_00_1_0_0_0_0});

        // load-use on rt, then same with $zero destination, then rs match
        id_valid = 1'b1; ex_load = 1'b1; ex_dst = 5'd8; id_rt = 5'd8; id_rt_use = 1'b1;
        step();
        check("load_use_rt", {24'd0, last_got}, {24'd0, 8'b0_00_0_0_1_0_0});
        ex_dst = 5'd0; id_rt = 5'd0;
        step();
        check("load_use_r0", {24'd0, last_got}, {24'd0, 8'b1_00_1_0_0_0_0});
        ex_dst = 5'd3; id_rs = 5'd3; id_rs_use = 1'b1; id_rt = 5'd9;
        step();
        check("load_use_rs", {24'd0, last_got}, {24'd0, 8'b0_00_0_0_1_0_0});
        id_rs_use = 1'b0;
        step();
        check("no_use_flag", {24'd0, last_got}, {24'd0, 8'b1_00_1_0_0_0_0});
        idle_inputs();

        // div then mult latency seen by a waiting HI/LO reader
        for (int k = 0; k < 2; k++) begin
            ex_md_start = 1'b1;
            ex_md_div   = (k == 0);
            step();
            ex_md_start = 1'b0;
            ex_md_div   = 1'b0;
            id_valid    = 1'b1;
            id_md_use   = 1'b1;
            n = 0;
            for (int c = 0; c < 20; c++) begin
                step();
                if (last_got[0] !== 1'b1) break;
                n++;
            end
            check(k == 0 ? "div_busy_len" : "mult_busy_len", n, k == 0 ? 32'd10 : 32'd5);
            check("md_done_pcwe", {31'd0, last_got[7]}, 32'd1);
            idle_inputs();
        end

        // exception beats load-use, wrong-path exception dropped, then accepted again
        id_valid = 1'b1; ex_load = 1'b1; ex_dst = 5'd8; id_rt = 5'd8; id_rt_use = 1'b1;
        exc_req = 1'b1;
        step();
        check("exc_over_stall", {24'd0, last_got}, {24'd0, 8'b1_01_0_1_1_1_0});
        idle_inputs();
        exc_req = 1'b1;
        step();
        check("exc_in_recover", {24'd0, last_got}, {24'd0, 8'b1_00_1_0_0_0_0});
        step();
        check("exc_accepted", {24'd0, last_got}, {24'd0, 8'b1_01_0_1_1_1_0});
        exc_req = 1'b0;
        step();

        // eret/exc priority, then eret alone and its recovery cycle
        exc_req = 1'b1; eret_req = 1'b1;
        step();
        check("exc_beats_eret", {24'd0, last_got}, {24'd0, 8'b1_01_0_1_1_1_0});
        exc_req = 1'b0; eret_req = 1'b0;
        step();
        eret_req = 1'b1;
        step();
        check("eret_redirect", {24'd0, last_got}, {24'd0, 8'b1_10_0_1_1_1_0});
        eret_req = 1'b0; exc_req = 1'b1;
        step();
        check("eret_recover", {24'd0, last_got}, {24'd0, 8'b1_00_1_0_0_0_0});
        idle_inputs();

        // reissue mid-count reloads the full mult latency
        ex_md_start = 1'b1;
        step();
        ex_md_start = 1'b0;
        step();
        step();
        step();
        ex_md_start = 1'b1;
        step();
        check("reload_at_2", {31'd0, last_got[0]}, 32'd1);
        ex_md_start = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (last_got[0] !== 1'b1) break;
            n++;
        end
        check("reload_busy_len", n, 32'd5);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
